// File: rtl/aes128_wb_regs.sv
// Wishbone register front-end for an aes128 core: key/plaintext registers, start/busy/done control, ciphertext capture.
// Latency: ack one cycle after a hit; ciphertext captured exactly LATENCY edges after the START commit edge.
// Backpressure: none; every in-window access is acked in one cycle, KEY/STATE/START writes are dropped while busy.
module aes128_wb_regs #(
    parameter int unsigned  LATENCY   = 21,
    parameter logic [31:0]  BASE_ADDR = 32'h3000_0000
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [127:0] key_o,
    output logic [127:0] state_o,
    input  logic [127:0] out_i,
    output logic         irq_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [7:0] LAT8    = LATENCY[7:0];

    logic [0:0]   fsm;
    logic [7:0]   cnt;
    logic [127:0] key_q;
    logic [127:0] state_q;
    logic [127:0] out_q;
    logic         irq_en;
    logic         done;
    logic [31:0]  rdata;

    logic       hit, aligned, wr_en, rd_en, run;
    logic       start_req, ctrl_wr, done_clr, capture;
    logic [5:0] waddr;

    // Word 0 of each 128-bit register is the most significant 32 bits.
    function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = v[127:96];
            2'd1:    w = v[95:64];
            2'd2:    w = v[63:32];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] idx,
                                              input logic [31:0] w, input logic [3:0] sel);
        logic [127:0] r;
        logic [31:0]  m;
        m = get_word(v, idx);
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) m[8*b +: 8] = w[8*b +: 8];
        end
        r = v;
        case (idx)
            2'd0:    r[127:96] = m;
            2'd1:    r[95:64]  = m;
            2'd2:    r[63:32]  = m;
            default: r[31:0]   = m;
        endcase
        return r;
    endfunction

    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign aligned   = (wbs_adr_i[1:0] == 2'b00);
    assign waddr     = wbs_adr_i[7:2];
    assign wr_en     = hit & wbs_we_i & aligned;
    assign rd_en     = hit & ~wbs_we_i;
    assign run       = (fsm == ST_RUN);
    assign ctrl_wr   = wr_en & (waddr == 6'h08) & wbs_sel_i[0];
    assign start_req = ctrl_wr & wbs_dat_i[0] & ~run;
    assign done_clr  = wr_en & (waddr == 6'h09) & wbs_sel_i[0] & wbs_dat_i[1];
    assign capture   = run & (cnt == 8'd1);

    always_comb begin
        rdata = '0;
        if (aligned) begin
            case (waddr)
                6'h00, 6'h01, 6'h02, 6'h03: rdata = get_word(key_q, waddr[1:0]);
                6'h04, 6'h05, 6'h06, 6'h07: rdata = get_word(state_q, waddr[1:0]);
                6'h08:                      rdata = {30'd0, irq_en, 1'b0};
                6'h09:                      rdata = {30'd0, done, run};
                6'h0C, 6'h0D, 6'h0E, 6'h0F: rdata = get_word(out_q, waddr[1:0]);
                default:                    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            key_q     <= '0;
            state_q   <= '0;
            out_q     <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            fsm       <= ST_IDLE;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= rd_en ? rdata : '0;

            // Key and plaintext are frozen while the core is working on them.
            if (wr_en && !run) begin
                if (waddr[5:2] == 4'h0)
                    key_q <= put_word(key_q, waddr[1:0], wbs_dat_i, wbs_sel_i);
                if (waddr[5:2] == 4'h1)
                    state_q <= put_word(state_q, waddr[1:0], wbs_dat_i, wbs_sel_i);
            end

            if (ctrl_wr)
                irq_en <= wbs_dat_i[1];

            case (fsm)
                ST_IDLE: begin
                    if (start_req) begin
                        fsm  <= ST_RUN;
                        done <= 1'b0;
                        cnt  <= LAT8;
                    end else if (done_clr) begin
                        done <= 1'b0;
                    end
                end
                default: begin
                    cnt <= cnt - 8'd1;
                    // A clear landing on the capture edge loses to the new completion.
                    if (capture) begin
                        out_q <= out_i;
                        done  <= 1'b1;
                        fsm   <= ST_IDLE;
                    end else if (done_clr) begin
                        done <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign key_o   = key_q;
    assign state_o = state_q;
    assign irq_o   = done & irq_en;

endmodule

// File: tb/tb_aes128_wb_regs.sv
// Directed bench for aes128_wb_regs: read data goes through a scoreboard queue, a core model
// presents the ciphertext only on the exact capture cycle so capture timing is checked too.
module tb_aes128_wb_regs;

    localparam int          LAT  = 21;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  adr = '0, wdat = '0;
    logic         ack;
    logic [31:0]  rdat;
    logic [127:0] key_o, state_o, out_i;
    logic         irq;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;
    int start_edge = -1000;
    int commit_edge = 0;
    int irq_rise = -1;
    int irq_fall = -1;
    logic irq_prev = 1'b0;
    logic [31:0] exp_q[$];

    aes128_wb_regs #(.LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .key_o    (key_o),
        .state_o  (state_o),
        .out_i    (out_i),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Core model: ciphertext is valid only on the cycle feeding the capture edge.
    assign out_i = (edge_n == start_edge + LAT - 1) ? CT : ~CT;

    always @(negedge clk) begin
        if (irq && !irq_prev) irq_rise <= edge_n;
        if (!irq && irq_prev) irq_fall <= edge_n;
        irq_prev <= irq;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic exp_ack, input logic [31:0] exp_rd,
                       input string tag);
        logic seen;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        if (!w && exp_ack) exp_q.push_back(exp_rd);
        @(negedge clk);
        seen = ack;
        if (ack) begin
            commit_edge = edge_n;
            if (!w) begin
                if (exp_q.size() > 0) begin
                    chk(tag, {96'd0, rdat}, {96'd0, exp_q.pop_front()});
                end else begin
                    n_checks++;
                    n_errors++;
                    $error("FAIL %s_sb unexpected read data observed=%h expected=none", tag, rdat);
                end
            end
        end
        if (!exp_ack) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                seen = seen | ack;
            end
        end
        chk({tag, "_ack"}, {127'd0, seen}, {127'd0, exp_ack});
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        if (exp_ack) chk({tag, "_ack1"}, {127'd0, ack}, 128'd0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input string tag);
        bus(1'b1, BASE + {24'd0, off}, d, 4'hF, 1'b1, 32'd0, tag);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] expv, input string tag);
        bus(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF, 1'b1, expv, tag);
    endtask

    task automatic wait_edge(input int target, input string tag);
        int g = 0;
        while (edge_n < target && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_timeout"}, {127'd0, edge_n >= target}, 128'd1);
    endtask

    initial begin
        logic [31:0] ct_w;
        logic [127:0] ct_v;
        ct_v = CT;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {127'd0, ack}, 128'd0);
        chk("rst_dat", {96'd0, rdat}, 128'd0);
        chk("rst_irq", {127'd0, irq}, 128'd0);
        chk("rst_key", key_o, 128'd0);
        chk("rst_state", state_o, 128'd0);
        rst = 1'b0;

        for (int o = 0; o < 16; o++) rd(8'(o * 4), 32'd0, $sformatf("rst_rd_%02h", o * 4));

        // Byte-lane write and window decode
        bus(1'b1, BASE + 32'h04, 32'hAABBCCDD, 4'b0010, 1'b1, 32'd0, "key1_sel_wr");
        rd(8'h04, 32'h0000CC00, "key1_sel");
        bus(1'b0, BASE + 32'h100, 32'd0, 4'hF, 1'b0, 32'd0, "miss");
        rd(8'h40, 32'd0, "unmapped_40");

        for (int i = 0; i < 4; i++) begin
            wr(8'(i * 4), KEY[127 - 32 * i -: 32], "key_wr");
            wr(8'(16 + i * 4), PT[127 - 32 * i -: 32], "state_wr");
        end
        rd(8'h08, KEY[63:32], "key2_rd");
        chk("key_o", key_o, KEY);
        chk("state_o", state_o, PT);
        wr(8'h20, 32'h2, "irqen_wr");
        rd(8'h20, 32'h2, "ctrl_rd");

        // First encryption: BUSY, frozen key, capture timing, irq
        wr(8'h20, 32'h3, "start1");
        start_edge = commit_edge;
        rd(8'h24, 32'h1, "status_busy");
        wr(8'h00, 32'hDEADBEEF, "key0_run_wr");
        rd(8'h00, KEY[127:96], "key0_run");
        chk("key_o_run", key_o, KEY);
        wait_edge(start_edge + LAT + 1, "run1");
        chk("irq_rise_edge", 128'(irq_rise), 128'(start_edge + LAT));
        rd(8'h24, 32'h2, "status_done");
        for (int i = 0; i < 4; i++) begin
            ct_w = ct_v[127 - 32 * i -: 32];
            rd(8'h30 + 8'(i * 4), ct_w, $sformatf("out%0d", i));
        end
        wr(8'h30, 32'h12345678, "out0_wr");
        rd(8'h30, CT[127:96], "out0_ro");

        // DONE write-1-to-clear drops irq the following cycle
        wr(8'h24, 32'h2, "done_clr");
        chk("irq_fall_edge", 128'(irq_fall), 128'(commit_edge));
        chk("irq_low", {127'd0, irq}, 128'd0);
        rd(8'h24, 32'h0, "status_clr");

        // Second run: old OUT held until the new capture
        wr(8'h20, 32'h3, "start2");
        start_edge = commit_edge;
        rd(8'h30, CT[127:96], "out0_old");
        wait_edge(start_edge + LAT + 1, "run2");
        rd(8'h24, 32'h2, "status_done2");

        // START with DONE set, then reset mid-run
        wr(8'h20, 32'h3, "start3");
        start_edge = commit_edge;
        rd(8'h24, 32'h1, "status_restart");
        wait_edge(start_edge + 5, "pre_rst");
        rst = 1'b1;
        #1;
        chk("mid_rst_irq", {127'd0, irq}, 128'd0);
        chk("mid_rst_key", key_o, 128'd0);
        chk("mid_rst_ack", {127'd0, ack}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_edge(start_edge + LAT + 3, "post_rst");
        rd(8'h24, 32'h0, "status_after_rst");
        rd(8'h30, 32'h0, "out0_after_rst");
        rd(8'h20, 32'h0, "ctrl_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes128_wb_regs.md
AES128_WB_REGS -- requirements
Module: aes128_wb_regs

Interface
REQ-001 Parameter: LATENCY, default 21, cycles from input apply to valid core output (range 1..255).
REQ-002 Parameter: BASE_ADDR, default 32'h3000_0000, window base; decode on wbs_adr_i[31:8].
REQ-003 Port: wb_clk_i  input  1  single clock for all state.
REQ-004 Port: wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 Port: wbs_cyc_i / wbs_stb_i / wbs_we_i  input  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-006 Port: wbs_sel_i  input  4  byte selects.
REQ-007 Port: wbs_adr_i  input  32  byte address.
REQ-008 Port: wbs_dat_i  input  32  write data.
REQ-009 Port: wbs_ack_o  output  1  transfer acknowledge.
REQ-010 Port: wbs_dat_o  output  32  read data.
REQ-011 Port: key_o  output  128  cipher key to aes128 core.
REQ-012 Port: state_o  output  128  plaintext to aes128 core.
REQ-013 Port: out_i  input  128  ciphertext from aes128 core.
REQ-014 Port: irq_o  output  1  completion interrupt.

Function
REQ-015 Hit = cyc & stb & (adr[31:8]==BASE_ADDR[31:8]) & !ack; ack SHALL assert on the edge after hit, high exactly one cycle; no ack for misses.
REQ-016 Writes commit on the edge that raises ack; reads return registered data valid while ack is high.
REQ-017 Map (adr[7:0]): 0x00-0x0C KEY0-3 RW, KEY0=key_o[127:96] ... KEY3=key_o[31:0]; 0x10-0x1C STATE0-3 RW, same ordering on state_o.
REQ-018 0x20 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN RW; other bits read 0.
REQ-019 0x24 STATUS: bit0 BUSY RO, bit1 DONE (write-1-to-clear); other bits read 0.
REQ-020 0x30-0x3C OUT0-3 RO, OUT0=captured ciphertext[127:96]; writes ignored but acked.
REQ-021 Unmapped offsets in window: read 0, writes ignored, always acked.
REQ-022 KEY/STATE writes honour wbs_sel_i per byte; CTRL/STATUS use byte 0 only.
REQ-023 FSM IDLE/RUN; IDLE->RUN on START write: BUSY=1, DONE=0, counter loaded with LATENCY.
REQ-024 RUN: counter decrements each edge; on edge where counter==1, OUT0-3 <= out_i, BUSY=0, DONE=1, return IDLE.
REQ-025 Capture edge SHALL be exactly LATENCY edges after the START commit edge.
REQ-026 In RUN: KEY/STATE writes ignored (acked), START ignored; IRQ_EN and DONE-clear remain writable.
REQ-027 START in IDLE with DONE=1 clears DONE and starts a new operation; OUT keeps old value until next capture.
REQ-028 DONE clear write on the same edge as capture: set wins (DONE=1).
REQ-029 irq_o = DONE & IRQ_EN, combinational from registers.
REQ-030 key_o/state_o driven directly from KEY/STATE registers, stable throughout RUN.

Reset
REQ-031 On wb_rst_i high, asynchronously: KEY, STATE, OUT, counter = 0; IRQ_EN=0; BUSY=0; DONE=0; FSM=IDLE; wbs_ack_o=0; wbs_dat_o=0; irq_o=0.
REQ-032 Reset mid-RUN aborts the operation; no capture after release; no ack for a cycle interrupted by reset.

Verification
REQ-033 Reset, read every mapped offset -> all 0, each ack single-cycle, irq_o=0.
REQ-034 KEY0-3=000102030405060708090a0b0c0d0e0f, STATE0-3=00112233445566778899aabbccddeeff, START, with real aes128 -> BUSY for 21 cycles, OUT0-3=69c4e0d8 6a7b0430 d8cdb780 70b4c55a, DONE=1.
REQ-035 IRQ_EN=1 then run -> irq_o rises on capture edge; write STATUS=0x2 -> irq_o falls next cycle.
REQ-036 Write KEY1 with sel=4'b0010, data 0xAABBCCDD -> KEY1=0x0000CC00; write KEY0 during RUN -> value unchanged, ack given.
REQ-037 Access at BASE_ADDR+0x100 -> no ack; offset 0x40 read -> 0 with ack.
REQ-038 Assert wb_rst_i 5 cycles after START -> BUSY=0, DONE=0, OUT=0 immediately; no capture after release.
